// File: rtl/stopwatch_ctrl_if.sv
// Stopwatch control bus: tick/button/switch inputs toward the controller and
// the time register plus display status coming back from it.
interface stopwatch_ctrl_if;
   logic       tick_1hz;
   logic       tick_2hz;
   logic       btn_pause;
   logic       btn_clear;
   logic       sw_adj;
   logic       sw_sel;
   logic [5:0] minutes;
   logic [5:0] seconds;
   logic       running;
   logic       blank_min;
   logic       blank_sec;

   // Upstream side: drives ticks and user controls, observes the time.
   modport master (
      output tick_1hz, tick_2hz, btn_pause, btn_clear, sw_adj, sw_sel,
      input  minutes, seconds, running, blank_min, blank_sec
   );

   // Controller side.
   modport slave (
      input  tick_1hz, tick_2hz, btn_pause, btn_clear, sw_adj, sw_sel,
      output minutes, seconds, running, blank_min, blank_sec
   );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch mode controller: RUN/PAUSE/ADJ sequencing, MM:SS time register
// and per-field blanking for adjust-mode blinking. All outputs come straight
// from flops so the 7-seg mux sees no input-to-output combinational path.
module stopwatch_ctrl #(
   parameter int MIN_MAX = 59,
   parameter int SEC_MAX = 59
) (
   input  logic             clk,
   input  logic             rst,
   stopwatch_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_PAUSE = 2'd1,
      ST_ADJ   = 2'd2
   } state_t;

   localparam logic [5:0] MIN_TOP = 6'(MIN_MAX);
   localparam logic [5:0] SEC_TOP = 6'(SEC_MAX);

   state_t     state_q, state_d;
   logic [5:0] min_q, min_d;
   logic [5:0] sec_q, sec_d;
   logic       blink_q, blink_d;
   logic       btn_pause_q, btn_pause_d;
   logic       blank_min_q, blank_min_d;
   logic       blank_sec_q, blank_sec_d;
   logic       pause_pulse;

   // Increment with wrap to zero once the terminal value is reached.
   function automatic logic [5:0] inc_wrap(input logic [5:0] value, input logic [5:0] top);
      logic [5:0] result;
      if (value == top) begin
         result = 6'd0;
      end else begin
         result = value + 6'd1;
      end
      return result;
   endfunction

   // Rising-edge detect on the debounced pause button.
   always_comb begin
      btn_pause_d = bus.btn_pause;
      pause_pulse = bus.btn_pause & ~btn_pause_q;
   end

   // Next-state: adjust switch dominates; leaving ADJ always lands in PAUSE.
   always_comb begin
      state_d = state_q;
      if (bus.sw_adj) begin
         state_d = ST_ADJ;
      end else begin
         case (state_q)
            ST_ADJ:   state_d = ST_PAUSE;
            ST_RUN:   state_d = pause_pulse ? ST_PAUSE : ST_RUN;
            ST_PAUSE: state_d = pause_pulse ? ST_RUN : ST_PAUSE;
            default:  state_d = ST_RUN;
         endcase
      end
   end

   // Time register update: clear beats adjust beats normal counting.
   always_comb begin
      min_d = min_q;
      sec_d = sec_q;
      if (bus.btn_clear) begin
         min_d = 6'd0;
         sec_d = 6'd0;
      end else if ((state_q == ST_ADJ) && bus.tick_2hz) begin
         if (bus.sw_sel) begin
            min_d = inc_wrap(min_q, MIN_TOP);
         end else begin
            sec_d = inc_wrap(sec_q, SEC_TOP);
         end
      end else if ((state_q == ST_RUN) && bus.tick_1hz) begin
         sec_d = inc_wrap(sec_q, SEC_TOP);
         if (sec_q == SEC_TOP) begin
            min_d = inc_wrap(min_q, MIN_TOP);
         end else begin
            min_d = min_q;
         end
      end else begin
         min_d = min_q;
         sec_d = sec_q;
      end
   end

   // Blink phase and blanking, computed against the state being entered so
   // the registered blanks line up with the registered state.
   always_comb begin
      blink_d = 1'b0;
      if (state_d != ST_ADJ) begin
         blink_d = 1'b0;
      end else if ((state_q == ST_ADJ) && bus.tick_2hz) begin
         blink_d = ~blink_q;
      end else begin
         blink_d = blink_q;
      end
      blank_min_d = (state_d == ST_ADJ) &  bus.sw_sel & blink_d;
      blank_sec_d = (state_d == ST_ADJ) & ~bus.sw_sel & blink_d;
   end

   // All controller state, asynchronously reset to 00:00 running.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_RUN;
         min_q       <= 6'd0;
         sec_q       <= 6'd0;
         blink_q     <= 1'b0;
         btn_pause_q <= 1'b0;
         blank_min_q <= 1'b0;
         blank_sec_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         min_q       <= min_d;
         sec_q       <= sec_d;
         blink_q     <= blink_d;
         btn_pause_q <= btn_pause_d;
         blank_min_q <= blank_min_d;
         blank_sec_q <= blank_sec_d;
      end
   end

   assign bus.minutes   = min_q;
   assign bus.seconds   = sec_q;
   assign bus.running   = (state_q == ST_RUN);
   assign bus.blank_min = blank_min_q;
   assign bus.blank_sec = blank_sec_q;

endmodule
